// File: rtl/l2_bus_arbiter_pkg.sv
// l2_bus_arbiter_pkg: FSM encoding, default bus widths and index-width helper for the L2 bus arbiter
package l2_bus_arbiter_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, INV = 2'd2} state_t;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/l2_bus_arbiter_rr_pick.sv
// l2_bus_arbiter_rr_pick: combinational round-robin picker, first set req at ptr, ptr+1, ... wrapping mod N
module l2_bus_arbiter_rr_pick
    import l2_bus_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt,
    output logic          any
);
    // Descending scan so the candidate closest to ptr is the last (winning) write
    always_comb begin
        gnt = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt = PW'((int'(ptr) + k) % N);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/l2_bus_arbiter.sv
// l2_bus_arbiter: round-robin share of the L2 front-end among N back-ends, with idle-only invalidate sequencing
module l2_bus_arbiter
    import l2_bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
    output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic                          s_valid,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready,
    input  logic                          inv_req,
    output logic                          s_force_inv,
    output logic                          inv_busy
);
    localparam int PW = idx_w(N_MASTERS);
    localparam int SW = DATA_W / 8;
    state_t state, state_n;
    logic [PW-1:0] ptr, gnt, pick;
    logic any, inv_pending, busy;
    l2_bus_arbiter_rr_pick #(.N(N_MASTERS), .PW(PW)) u_pick (
        .req(m_valid),
        .ptr(ptr),
        .gnt(pick),
        .any(any)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt         <= '0;
            inv_pending <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && !inv_pending && any)
                gnt <= pick;
            if (busy && s_ready)
                ptr <= (gnt == PW'(N_MASTERS - 1)) ? '0 : gnt + PW'(1);
            // A new request in the cycle that consumes the pending one keeps it set
            inv_pending <= inv_req | (inv_pending & (state != IDLE));
        end
    end
    always_comb begin
        state_n = state == INV  ? IDLE :
                  state == BUSY ? (s_ready ? IDLE : BUSY) :
                  inv_pending   ? INV :
                  any           ? BUSY : IDLE;
    end
    assign busy        = state == BUSY;
    assign s_valid     = busy & m_valid[gnt];
    assign s_addr      = busy ? m_addr[gnt*ADDR_W +: ADDR_W] : '0;
    assign s_wdata     = busy ? m_wdata[gnt*DATA_W +: DATA_W] : '0;
    assign s_wstrb     = busy ? m_wstrb[gnt*SW +: SW] : '0;
    assign m_ready     = (busy & s_ready) ? N_MASTERS'(1) << gnt : '0;
    assign m_rdata     = {N_MASTERS{s_rdata}};
    assign s_force_inv = state == INV;
    assign inv_busy    = inv_pending | (state == INV);
endmodule

// File: tb/tb_l2_bus_arbiter.sv
// tb_l2_bus_arbiter: randomized protocol-following masters checked against a transaction-level arbiter model
module tb_l2_bus_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]    m_valid = '0;
    logic [N*AW-1:0] m_addr  = '0;
    logic [N*DW-1:0] m_wdata = '0;
    logic [N*SW-1:0] m_wstrb = '0;
    logic [N*DW-1:0] m_rdata;
    logic [N-1:0]    m_ready;
    logic            s_valid;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic [DW-1:0]   s_rdata = '0;
    logic            s_ready = 1'b0;
    logic            inv_req = 1'b0;
    logic            s_force_inv;
    logic            inv_busy;
    int total = 0;
    int bad   = 0;
    always #5 clk = ~clk;
    l2_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .inv_req(inv_req), .s_force_inv(s_force_inv), .inv_busy(inv_busy)
    );
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Model: owner = master holding the front-end (-1 when none), inv_now = invalidate
    // pulse this cycle, pend = invalidate owed, next_first = where the fair search starts.
    int owner = -1;
    int next_first = 0;
    bit inv_now = 0;
    bit pend = 0;
    bit active [N];
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];
    logic [SW-1:0] w [N];
    logic [N-1:0] exp_ready;
    int last_served = -1;
    initial begin
        for (int i = 0; i < N; i++) begin
            active[i] = 0; a[i] = '0; d[i] = '0; w[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_s_valid", s_valid, 1'b0);
        check("rst_m_ready", m_ready, '0);
        check("rst_s_addr", s_addr, '0);
        check("rst_force_inv", s_force_inv, 1'b0);
        check("rst_inv_busy", inv_busy, 1'b0);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(149) == 0);
            for (int i = 0; i < N; i++) begin
                if (!active[i] && $urandom_range(2) == 0) begin
                    active[i] = 1;
                    a[i] = $urandom;
                    d[i] = $urandom;
                    w[i] = $urandom_range(1) ? '0 : SW'($urandom_range(15));
                end
                m_valid[i]           = active[i];
                m_addr[i*AW +: AW]   = a[i];
                m_wdata[i*DW +: DW]  = d[i];
                m_wstrb[i*SW +: SW]  = w[i];
            end
            s_rdata = $urandom;
            s_ready = ($urandom_range(9) < 4);
            inv_req = ($urandom_range(9) == 0);
            #1;
            exp_ready = '0;
            if (owner >= 0 && s_ready) exp_ready[owner] = 1'b1;
            check("s_valid", s_valid, owner >= 0 && active[owner]);
            check("s_addr", s_addr, owner >= 0 ? a[owner] : '0);
            check("s_wdata", s_wdata, owner >= 0 ? d[owner] : '0);
            check("s_wstrb", s_wstrb, owner >= 0 ? w[owner] : '0);
            check("m_ready", m_ready, exp_ready);
            check("m_rdata", m_rdata, {N{s_rdata}});
            check("s_force_inv", s_force_inv, inv_now);
            check("inv_busy", inv_busy, pend | inv_now);
            @(posedge clk);
            if (rst) begin
                owner = -1; next_first = 0; inv_now = 0; pend = 0; last_served = -1;
            end else begin
                bit new_pend;
                new_pend = pend | inv_req;
                if (inv_now) begin
                    inv_now = 0;
                end else if (owner >= 0) begin
                    if (s_ready) begin
                        active[owner] = 0;
                        last_served = owner;
                        next_first = (owner + 1) % N;
                        owner = -1;
                    end
                end else if (pend) begin
                    inv_now = 1;
                    new_pend = inv_req;
                end else begin
                    for (int k = 0; k < N && owner < 0; k++)
                        if (active[(next_first + k) % N]) owner = (next_first + k) % N;
                end
                pend = new_pend;
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
